// File: rtl/mac_pkg.sv
// mac_pkg
//   Shared types and constants for the shift-and-add MAC datapath.
//   - mac_state_t : controller states (IDLE, MULT, ACC)
//   - MAC_WIDTH_DEFAULT / MAC_ACC_WIDTH_DEFAULT : default operand and
//     accumulator widths
//   - cnt_width() : bit-counter width for a given operand width
package mac_pkg;

  localparam int MAC_WIDTH_DEFAULT     = 8;
  localparam int MAC_ACC_WIDTH_DEFAULT = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_ACC  = 2'd2
  } mac_state_t;

  // The counter indexes multiplier bits 0..w-1, so clog2(w) bits suffice.
  // It is clamped to at least one bit so that a degenerate width still
  // yields a legal vector.
  function automatic int cnt_width(input int w);
    int cw;
    cw = $clog2(w);
    if (cw < 1) cw = 1;
    return cw;
  endfunction

endpackage

// File: rtl/pp_gen.sv
// pp_gen
//   Combinational partial-product generator for the shift-and-add
//   multiplier: the multiplicand ANDed with one replicated multiplier bit.
//
// Ports
//   a      in  WIDTH  multiplicand
//   bit_in in  1      current multiplier bit
//   pp     out WIDTH  partial product (a when bit_in=1, else 0)
module pp_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             bit_in,
  output logic [WIDTH-1:0] pp
);

  assign pp = a & {WIDTH{bit_in}};

endmodule

// File: rtl/shift_add_mac.sv
// shift_add_mac
//   Sequential unsigned multiply-accumulate. One multiplier bit is consumed
//   per cycle; the finished product is then added into (or, with clear,
//   loaded into) a modulo-2^ACC_WIDTH accumulator. Operands enter through a
//   valid/ready handshake; each result is announced with a one-cycle pulse.
//   One operation takes WIDTH+2 cycles from accept to the next accept.
//
// Ports
//   clk       in  1          clock, rising edge
//   rst       in  1          asynchronous active-high reset
//   in_valid  in  1          a/b/clear are valid
//   in_ready  out 1          operands are accepted this cycle (IDLE only)
//   a         in  WIDTH      multiplicand, unsigned
//   b         in  WIDTH      multiplier, unsigned
//   clear     in  1          product replaces the accumulator instead of adding
//   acc_out   out ACC_WIDTH  accumulator value
//   out_valid out 1          one-cycle pulse after acc_out is updated
//   overflow  out 1          sticky: an accumulate wrapped; cleared by clear
//   busy      out 1          a multiply/accumulate is in progress
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready=1
// MULT  | WIDTH cycles, one shift-and-add of a partial product per cycle
// ACC   | one cycle, fold product into the accumulator, pulse out_valid
import mac_pkg::*;

module shift_add_mac #(
  parameter int WIDTH     = MAC_WIDTH_DEFAULT,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam int CNT_W  = cnt_width(WIDTH);
  localparam int PROD_W = 2 * WIDTH;

  mac_state_t              state;
  logic [WIDTH-1:0]        a_q;
  logic [WIDTH-1:0]        b_q;
  logic                    clear_q;
  logic [CNT_W-1:0]        cnt;
  logic [PROD_W-1:0]       product;
  logic [ACC_WIDTH-1:0]    acc;
  logic                    overflow_q;
  logic                    out_valid_q;

  logic [WIDTH-1:0]        pp;
  logic [PROD_W-1:0]       pp_shifted;
  logic [ACC_WIDTH:0]      acc_sum;
  logic                    last_bit;

  pp_gen #(
    .WIDTH (WIDTH)
  ) u_pp_gen (
    .a      (a_q),
    .bit_in (b_q[cnt]),
    .pp     (pp)
  );

  // Partial product placed at its bit weight inside the double-width product.
  assign pp_shifted = {{WIDTH{1'b0}}, pp} << cnt;

  // One extra bit on the sum exposes the carry out of the accumulator.
  assign acc_sum  = {1'b0, acc} + (ACC_WIDTH + 1)'(product);

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      clear_q     <= 1'b0;
      cnt         <= '0;
      product     <= '0;
      acc         <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            clear_q <= clear;
            cnt     <= '0;
            product <= '0;
            state   <= ST_MULT;
          end
        end

        ST_MULT: begin
          product <= product + pp_shifted;
          if (last_bit) begin
            state <= ST_ACC;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_ACC: begin
          if (clear_q) begin
            acc        <= ACC_WIDTH'(product);
            overflow_q <= 1'b0;
          end else begin
            acc <= acc_sum[ACC_WIDTH-1:0];
            if (acc_sum[ACC_WIDTH]) begin
              overflow_q <= 1'b1;
            end
          end
          out_valid_q <= 1'b1;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Both are decoded straight from the state register, so neither has a
  // combinational path from in_valid.
  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  assign acc_out   = acc;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_add_mac.sv
module tb_shift_add_mac;

  localparam int W  = 8;
  localparam int AW = 20;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          clear;
  logic [AW-1:0] acc_out;
  logic          out_valid;
  logic          overflow;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  shift_add_mac #(
    .WIDTH     (W),
    .ACC_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .clear     (clear),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  va;
    logic [W-1:0]  vb;
    logic          vclr;
    logic [AW-1:0] eacc;
    logic          eovf;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready at a falling edge; returns 1 if it arrived.
  task automatic wait_ready(output bit ok);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 30) begin
      @(negedge clk);
      g++;
    end
    ok = in_ready;
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [AW-1:0] eacc, input logic eovf, input string name);
    bit ok;
    int lat;
    int low;
    wait_ready(ok);
    a = ta;
    b = tb_v;
    clear = tc;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    low = 0;
    for (int k = 0; k < 15 && lat < 0; k++) begin
      @(negedge clk);
      if (!in_ready) low++;
      if (out_valid) lat = k;
    end
    check({name, "_latency"}, 32'(lat), 32'd9);
    check({name, "_ready_low"}, 32'(low), 32'd9);
    check({name, "_acc"}, 32'(acc_out), 32'(eacc));
    check({name, "_ovf"}, 32'(overflow), 32'(eovf));
    @(negedge clk);
    check({name, "_pulse_end"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    int pulses;

    vecs[0] = '{8'd3,   8'd5,   1'b1, 20'd15,    1'b0};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 20'd65040, 1'b0};
    vecs[2] = '{8'd10,  8'd10,  1'b0, 20'd65140, 1'b0};
    vecs[3] = '{8'd255, 8'd255, 1'b1, 20'd65025, 1'b0};
    for (int j = 1; j <= 15; j++)
      vecs[3 + j] = '{8'd255, 8'd255, 1'b0, 20'(65025 * (j + 1)), 1'b0};
    vecs[19] = '{8'd255, 8'd255, 1'b0, 20'd56849, 1'b1};
    vecs[20] = '{8'd2,   8'd2,   1'b1, 20'd4,     1'b0};
    vecs[21] = '{8'd0,   8'd200, 1'b0, 20'd4,     1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    clear = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_acc", 32'(acc_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vclr, vecs[i].eacc, vecs[i].eovf, $sformatf("vec%0d", i));

    // in_valid held high with changing operands while busy: only 3x4 counts.
    wait_ready(ok);
    a = 8'd3;
    b = 8'd4;
    clear = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
      if (k < 9) begin
        a = 8'($urandom_range(1, 255));
        b = 8'($urandom_range(1, 255));
        clear = 1'b1;
      end else begin
        in_valid = 1'b0;
        clear = 1'b0;
      end
    end
    check("hs_pulses", 32'(pulses), 32'd1);
    check("hs_acc", 32'(acc_out), 32'd16);
    check("hs_ovf", 32'(overflow), 32'd0);

    // Reset during MULT discards the operation.
    wait_ready(ok);
    a = 8'd5;
    b = 8'd5;
    clear = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_acc", 32'(acc_out), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("mid_no_pulse", 32'(pulses), 32'd0);
    run_op(8'd7, 8'd6, 1'b0, 20'd42, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_add_mac.md
# shift_add_mac

Sequential unsigned multiply-accumulate unit that consumes one multiplier bit per cycle. Each cycle a bitwise-AND partial product (multiplicand ANDed with the current multiplier bit) is shifted and added, and the finished product is added into a running accumulator. The block is the accumulating end of the MAC datapath: operands come in through a valid/ready handshake, and results go out as a one-cycle valid pulse.

## Interface
- `WIDTH`, default 8: operand width in bits, ≥ 2.
- `ACC_WIDTH`, default 20: accumulator width, ≥ 2*`WIDTH`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: operand pair `a`/`b` (and `clear`) is valid.
- `in_ready`  out  1: block can accept an operand pair this cycle.
- `a`  in  `WIDTH`: multiplicand, unsigned.
- `b`  in  `WIDTH`: multiplier, unsigned.
- `clear`  in  1: sampled with the operands; when 1, the product replaces the accumulator instead of adding to it.
- `acc_out`  out  `ACC_WIDTH`: accumulator value; stable between updates.
- `out_valid`  out  1: one-cycle pulse when `acc_out` has just been updated.
- `overflow`  out  1: sticky flag, set when an accumulate wraps.
- `busy`  out  1: a multiply is in progress.

## Operation
- Arithmetic is unsigned throughout.
- Product register is 2*`WIDTH` bits and cannot overflow.
- Accumulation is modulo 2^`ACC_WIDTH`.
- States: IDLE, MULT, ACC.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `a`, `b`, `clear`; zero the product register and bit counter; go to MULT.
- MULT (exactly `WIDTH` cycles, counter i = 0..`WIDTH`-1):
  - product += (a & {`WIDTH`{b[i]}}) << i.
  - After i = `WIDTH`-1, go to ACC.
- ACC (1 cycle):
  - If the latched `clear`=1: acc ← zero-extended product, and `overflow` ← 0.
  - Otherwise: acc ← acc + product. If the add carries out of `ACC_WIDTH` bits, set `overflow`.
  - Pulse `out_valid`; return to IDLE.
- `in_ready` = (state == IDLE). Operands presented while not ready are ignored, not queued.
- `busy` = (state != IDLE).
- Input changes during MULT/ACC have no effect; the latched copies are used.
- `a`=0 or `b`=0 still takes the full `WIDTH`+1 cycles; there is no early exit.
- Reset, at any time including mid-multiply:
  - State goes to IDLE; accumulator, product, counter, `overflow` and `out_valid` are cleared.
  - The in-flight operation is discarded, with no `out_valid`.

## Timing
- Reset values: `in_ready`=1, `acc_out`=0, `out_valid`=0, `overflow`=0, `busy`=0.
- Accept edge = cycle 0. MULT occupies cycles 1..`WIDTH`, ACC is cycle `WIDTH`+1.
- The `out_valid` pulse and updated `acc_out`/`overflow` are visible in cycle `WIDTH`+1, i.e. `WIDTH`+1 cycles after the accept edge.
- `in_ready` returns high in cycle `WIDTH`+2.
- Throughput: one operation per `WIDTH`+2 cycles.
- `in_ready` is a registered function of state, with no combinational path from `in_valid`.
- `acc_out`, `overflow` and `out_valid` are registered.

## Structure
- Shared package `mac_pkg`:
  - state enum (IDLE, MULT, ACC);
  - default `WIDTH`/`ACC_WIDTH` constants;
  - counter width = clog2(`WIDTH`).
- One sub-module, `pp_gen`: combinational `WIDTH`-bit AND of the multiplicand with a replicated multiplier bit, producing the partial product.
- Top level holds the FSM, counter, product and accumulator registers.

## Test plan
All scenarios use `WIDTH`=8, `ACC_WIDTH`=20.
- Reset, then `a`=3, `b`=5, `clear`=1 → `out_valid` pulses 9 cycles after accept; `acc_out`=15; `overflow`=0.
- Back-to-back accumulate:
  - 15 (`clear`=1), then 255×255 with `clear`=0 → `acc_out`=65040.
  - Then 10×10 with `clear`=0 → `acc_out`=65140.
  - `in_ready` is low for 9 cycles after each accept.
- Overflow:
  - Load 255×255 with `clear`=1, then 15 more 255×255 with `clear`=0 → `acc_out`=1040400 with `overflow`=0.
  - The 17th operation → `acc_out`=1105425 mod 2^20 = 56849, `overflow`=1.
  - Next `clear`=1 op, 2×2 → `acc_out`=4, `overflow`=0.
- Zero operands: `a`=0, `b`=200, `clear`=0 on acc=4 → `acc_out`=4 after the full 9 cycles; `out_valid` pulses.
- Handshake: `in_valid` held high with changing `a`/`b` while `busy` → only the pair present on the accept edge is used; no extra `out_valid`.
- Mid-op reset: assert `rst` in MULT cycle 4 → `acc_out`=0, `busy`=0, `in_ready`=1 immediately; no `out_valid` follows; the next op 7×6 with `clear`=0 gives `acc_out`=42.
